// File: rtl/gf180mcu_fd_sc_mcu7t5v0__dffq_pipe.sv
`default_nettype none
// ============================================================================
// Module   : gf180mcu_fd_sc_mcu7t5v0__dffq_pipe
// Purpose  : Elastic valid/ready register pipeline of DEPTH stages. Each
//            stage holds WIDTH data bits and a valid bit. All data flops are
//            also stitched into a single scan chain.
// Ports    : CLK  - clock, rising-edge active
//            RST  - asynchronous active-high reset
//            VDD/VSS - power pins (only with USE_POWER_PINS, no function)
//            D/DV/DR - upstream data / valid / ready
//            Q/QV/QR - downstream data / valid / ready
//            SE/SI/SO - scan enable / scan in / scan out
//            CNT  - number of occupied stages
// Revision : 1.0 - initial release
// ============================================================================
module gf180mcu_fd_sc_mcu7t5v0__dffq_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
`ifdef USE_POWER_PINS
    inout  wire                          VDD,
    inout  wire                          VSS,
`endif
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [WIDTH-1:0]             D,
    input  logic                         DV,
    output logic                         DR,
    output logic [WIDTH-1:0]             Q,
    output logic                         QV,
    input  logic                         QR,
    input  logic                         SE,
    input  logic                         SI,
    output logic                         SO,
    output logic [$clog2(DEPTH+1)-1:0]   CNT
);

    localparam int C_CHAIN = WIDTH * DEPTH;
    localparam int C_CW    = $clog2(DEPTH + 1);

    // Stage 0 is the input side, stage DEPTH-1 drives Q.
    logic [DEPTH-1:0][WIDTH-1:0] r_s;
    logic [DEPTH-1:0]            r_v;

    logic [DEPTH-1:0]            w_ready;   // stage k can accept a word this edge
    logic [DEPTH-1:0]            w_in_v;    // valid arriving into stage k
    logic [DEPTH-1:0][WIDTH-1:0] w_in_d;    // data arriving into stage k
    logic [C_CHAIN-1:0]          w_flat;
    logic [C_CHAIN-1:0]          w_shift;
    logic [C_CW-1:0]             w_cnt;

    // Ready ripples back from QR: a stage accepts when it is empty or when
    // its occupant moves on this same edge.
    always_comb begin
        w_ready = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (k == DEPTH - 1) begin
                w_ready[k] = !r_v[k] || QR;
            end else begin
                w_ready[k] = !r_v[k] || w_ready[k+1];
            end
        end
    end

    always_comb begin
        w_in_v    = '0;
        w_in_d    = '0;
        w_in_v[0] = DV;
        w_in_d[0] = D;
        for (int k = 1; k < DEPTH; k++) begin
            w_in_v[k] = r_v[k-1];
            w_in_d[k] = r_s[k-1];
        end
    end

    // Packed layout puts S[k][b] at bit k*WIDTH+b, which is exactly the scan
    // order SI -> S[0][0] ... S[DEPTH-1][WIDTH-1] -> SO.
    assign w_flat = r_s;

    generate
        if (C_CHAIN == 1) begin : g_shift_single
            assign w_shift = SI;
        end else begin : g_shift_multi
            assign w_shift = {w_flat[C_CHAIN-2:0], SI};
        end
    endgenerate

    always_comb begin
        w_cnt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_cnt = w_cnt + C_CW'(r_v[k]);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_s <= '0;
            r_v <= '0;
        end else if (SE) begin
            // Scan shifts data only; occupancy is frozen.
            r_s <= w_shift;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (w_ready[k]) begin
                    r_v[k] <= w_in_v[k];
                    // Data only loads with a valid word, so emptied stages
                    // keep their old contents instead of toggling.
                    if (w_in_v[k]) begin
                        r_s[k] <= w_in_d[k];
                    end
                end
            end
        end
    end

    assign DR  = !SE && w_ready[0];
    assign QV  = !SE && r_v[DEPTH-1];
    assign Q   = r_s[DEPTH-1];
    assign SO  = w_flat[C_CHAIN-1];
    assign CNT = w_cnt;

endmodule
`default_nettype wire

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__dffq_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_gf180mcu_fd_sc_mcu7t5v0__dffq_pipe
// Purpose  : Directed self-checking bench for the elastic pipeline
//            (WIDTH=8, DEPTH=4): reset, streaming, full/back-pressure,
//            drain, async reset, ripple, and scan chain behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gf180mcu_fd_sc_mcu7t5v0__dffq_pipe;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] D;
    logic       DV;
    logic       DR;
    logic [7:0] Q;
    logic       QV;
    logic       QR;
    logic       SE;
    logic       SI;
    logic       SO;
    logic [2:0] CNT;

    int checks = 0;
    int errors = 0;

    gf180mcu_fd_sc_mcu7t5v0__dffq_pipe #(
        .WIDTH (8),
        .DEPTH (4)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .D   (D),
        .DV  (DV),
        .DR  (DR),
        .Q   (Q),
        .QV  (QV),
        .QR  (QR),
        .SE  (SE),
        .SI  (SI),
        .SO  (SO),
        .CNT (CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    logic [31:0] pat;

    initial begin
        pat = 32'hDEADBEEF;
        RST = 1'b1; SE = 1'b0; SI = 1'b0; D = 8'h00; DV = 1'b0; QR = 1'b0;
        #2;
        // Reset values, before any clock edge
        chk("rst_q",   Q,   8'h00);
        chk("rst_qv",  QV,  1'b0);
        chk("rst_so",  SO,  1'b0);
        chk("rst_cnt", CNT, 3'd0);
        chk("rst_dr",  DR,  1'b1);
        step();
        RST = 1'b0;

        // Stream 0x01..0x08 with QR=1
        QR = 1'b1; DV = 1'b1; D = 8'h01;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (e >= 4) begin
                chk("stream_q",   Q,   8'(e - 3));
                chk("stream_qv",  QV,  1'b1);
                chk("stream_cnt", CNT, 3'd4);
            end else begin
                chk("stream_fill_qv", QV, 1'b0);
            end
            D = 8'(e + 1);
        end
        DV = 1'b0;
        for (int e = 9; e <= 11; e++) begin
            step();
            chk("flush_q",   Q,   8'(e - 3));
            chk("flush_cnt", CNT, 3'(12 - e));
        end
        step();
        chk("empty_qv",  QV,  1'b0);
        chk("empty_cnt", CNT, 3'd0);
        chk("empty_q",   Q,   8'h08);
        chk("empty_dr",  DR,  1'b1);

        // Fill with QR=0
        QR = 1'b0; DV = 1'b1;
        for (int e = 0; e < 4; e++) begin
            D = 8'hA1 + 8'(e);
            step();
        end
        chk("full_cnt", CNT, 3'd4);
        chk("full_dr",  DR,  1'b0);
        chk("full_q",   Q,   8'hA1);
        D = 8'hA5;
        step();
        chk("full_hold_q",   Q,   8'hA1);
        chk("full_hold_cnt", CNT, 3'd4);
        QR = 1'b1;
        #1;
        chk("full_qr_dr", DR, 1'b1);
        step();
        chk("full_move_q",   Q,   8'hA2);
        chk("full_move_cnt", CNT, 3'd4);
        DV = 1'b0;
        for (int e = 0; e < 4; e++) step();
        chk("full_drain_cnt", CNT, 3'd0);

        // Two words, ripple to end, then drain
        QR = 1'b0; DV = 1'b1; D = 8'h11;
        step();
        D = 8'h22;
        step();
        DV = 1'b0;
        step();
        step();
        chk("two_q",   Q,   8'h11);
        chk("two_cnt", CNT, 3'd2);
        QR = 1'b1;
        step();
        chk("two_d1_q",   Q,   8'h22);
        chk("two_d1_cnt", CNT, 3'd1);
        step();
        chk("two_d2_qv",  QV,  1'b0);
        chk("two_d2_cnt", CNT, 3'd0);
        chk("two_d2_dr",  DR,  1'b1);

        // Single word ripples to the last stage with QR=0
        QR = 1'b0; DV = 1'b1; D = 8'h5A;
        step();
        DV = 1'b0;
        chk("rip_cnt1", CNT, 3'd1);
        chk("rip_qv1",  QV,  1'b0);
        step();
        step();
        chk("rip_qv3",  QV,  1'b0);
        step();
        chk("rip_qv4",  QV,  1'b1);
        chk("rip_q4",   Q,   8'h5A);
        chk("rip_cnt4", CNT, 3'd1);
        step();
        chk("rip_hold_q", Q, 8'h5A);
        chk("rip_hold_qv", QV, 1'b1);
        QR = 1'b1;
        step();
        chk("rip_out_qv",  QV,  1'b0);
        chk("rip_out_cnt", CNT, 3'd0);

        // Async reset with three words resident
        QR = 1'b0; DV = 1'b1;
        for (int e = 0; e < 3; e++) begin
            D = 8'h31 + 8'(e);
            step();
        end
        DV = 1'b0;
        chk("arst_pre_cnt", CNT, 3'd3);
        chk("arst_pre_q",   Q,   8'h5A);
        #3;
        RST = 1'b1;
        #1;
        chk("arst_q",   Q,   8'h00);
        chk("arst_qv",  QV,  1'b0);
        chk("arst_cnt", CNT, 3'd0);
        chk("arst_so",  SO,  1'b0);
        chk("arst_dr",  DR,  1'b1);
        DV = 1'b1; D = 8'h44;
        step();
        chk("arst_hold_cnt", CNT, 3'd0);
        RST = 1'b0;
        step();
        chk("arst_first_cnt", CNT, 3'd1);
        DV = 1'b0;

        // Scan from reset state
        RST = 1'b1;
        #1;
        RST = 1'b0;
        SE = 1'b1;
        #1;
        chk("scan_dr", DR, 1'b0);
        chk("scan_qv", QV, 1'b0);
        for (int e = 1; e <= 32; e++) begin
            SI = pat[e-1];
            step();
            chk("scan_so", SO, (e < 32) ? 1'b0 : pat[0]);
            chk("scan_dr_e", DR, 1'b0);
            chk("scan_cnt_e", CNT, 3'd0);
        end
        // First-in bit sits at the top of the chain: S[3] = bits 0..7 reversed
        SE = 1'b0; SI = 1'b0;
        #1;
        chk("scan_q_order", Q,   8'hF7);
        chk("scan_resume_dr", DR, 1'b1);
        SE = 1'b1;
        for (int e = 1; e <= 31; e++) begin
            step();
            chk("scan_so_out", SO, pat[e]);
        end
        SE = 1'b0;

        // Valid bits hold during scan; normal mode resumes on shifted data
        RST = 1'b1;
        #1;
        RST = 1'b0;
        step();
        QR = 1'b0; DV = 1'b1; D = 8'h3C;
        step();
        chk("vh_cnt0", CNT, 3'd1);
        SE = 1'b1; QR = 1'b1; DV = 1'b1; SI = 1'b0;
        for (int e = 0; e < 3; e++) begin
            step();
            chk("vh_cnt",  CNT, 3'd1);
            chk("vh_dr",   DR,  1'b0);
            chk("vh_qv",   QV,  1'b0);
        end
        SE = 1'b0; DV = 1'b0; QR = 1'b0;
        step();
        step();
        step();
        chk("vh_qv_end", QV, 1'b1);
        chk("vh_q_end",  Q,  8'hE0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gf180mcu_fd_sc_mcu7t5v0__dffq_pipe.md
GF180MCU_FD_SC_MCU7T5V0__DFFQ_PIPE -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__dffq_pipe

Interface
REQ-001 Parameter WIDTH, default 8, meaning data bits per stage; legal range 1..64.
REQ-002 Parameter DEPTH, default 4, meaning number of register stages; legal range 1..16.
REQ-003 Port CLK  input  1  the single clock; all state updates on rising edge.
REQ-004 Port RST  input  1  asynchronous, active-high reset.
REQ-005 Port VDD, VSS  inout  1 each  present only when USE_POWER_PINS is defined; no functional effect.
REQ-006 Port D  input  WIDTH  upstream data.
REQ-007 Port DV  input  1  upstream valid.
REQ-008 Port DR  output  1  ready to upstream.
REQ-009 Port Q  output  WIDTH  data of last stage.
REQ-010 Port QV  output  1  valid of last stage.
REQ-011 Port QR  input  1  ready from downstream.
REQ-012 Port SE  input  1  scan enable.
REQ-013 Port SI  input  1  scan in.
REQ-014 Port SO  output  1  scan out.
REQ-015 Port CNT  output  clog2(DEPTH+1)  number of valid stages.

Function
REQ-016 Stage k (0..DEPTH-1) SHALL hold data register S[k] (WIDTH bits) and valid bit V[k]; stage 0 is input side, stage DEPTH-1 drives Q/QV.
REQ-017 Normal mode (SE=0): last stage advances when QR=1 or V[DEPTH-1]=0.
REQ-018 Normal mode: stage k<DEPTH-1 advances into k+1 when V[k]=1 and stage k+1 is empty or advancing.
REQ-019 Normal mode: DR SHALL equal (V[0]=0) or stage 0 advancing; DR is combinational from QR through the ready chain.
REQ-020 A transfer occurs on a CLK edge when DV=1 and DR=1; D loads into S[0] and V[0] sets.
REQ-021 A stage that empties and is not refilled on the same edge SHALL clear its V bit; its S bits hold (no toggling of invalid data).
REQ-022 Latency with QR held 1: data presented at edge n SHALL appear on Q with QV=1 after edge n+DEPTH-1 (i.e. DEPTH register delays).
REQ-023 Throughput with QR held 1: one word per cycle, no bubbles.
REQ-024 Full (all V=1, QR=0): DR=0, no state change; when QR rises, simultaneous output and input transfer on same edge, CNT unchanged.
REQ-025 Empty (all V=0): QV=0, DR=1; Q shows stale S[DEPTH-1].
REQ-026 CNT SHALL equal popcount of V[] at all times; range 0..DEPTH, never wraps.
REQ-027 Scan mode (SE=1): every CLK edge shifts the chain by one bit regardless of DV/QR; chain order SI -> S[0][0] -> S[0][1] ... S[0][WIDTH-1] -> S[1][0] ... -> S[DEPTH-1][WIDTH-1] -> SO.
REQ-028 SO SHALL equal S[DEPTH-1][WIDTH-1] in both modes (registered, no combinational SI->SO path).
REQ-029 Scan mode: V[] SHALL hold; DR and QV SHALL be forced 0; CNT reflects held V[].
REQ-030 SE falling: normal operation resumes next edge using shifted S[] and held V[].
REQ-031 DEPTH=1: single stage, DR = !V[0] or QR; chain length WIDTH.

Reset
REQ-032 RST=1 SHALL immediately, without CLK, clear all S[] and V[] to 0: Q=0, QV=0, SO=0, CNT=0, DR=1 (if SE=0).
REQ-033 RST asserted mid-transfer or mid-scan SHALL abort; no transfer on any edge while RST=1.
REQ-034 First transfer after RST deasserts SHALL occur on the first CLK edge with RST=0 satisfying REQ-020.

Verification (WIDTH=8, DEPTH=4)
REQ-035 Reset then stream 0x01..0x08 with DV=1, QR=1 -> Q=0x01 QV=1 after 4th edge, one word/cycle thereafter, CNT=4 steady.
REQ-036 Fill with QR=0 and 0xA1..0xA4 -> CNT=4, DR=0, Q=0xA1; raise QR with DV=1 D=0xA5 -> next edge Q=0xA2, CNT=4.
REQ-037 Fill 2 words, then QR=1 DV=0 -> QV drops after 2 output transfers, CNT 2->1->0, DR=1.
REQ-038 SE=1, SI pattern 32 bits 0xDEADBEEF LSB first, reset state -> SO=0 for 31 edges, then SO emits pattern in order; DR=QV=0 throughout; V[] unchanged.
REQ-039 Assert RST asynchronously between edges with CNT=3 -> Q=0, QV=0, CNT=0, SO=0 before next CLK edge.
REQ-040 Simultaneous DV=1 and empty pipe with QR=0 -> word ripples to stage 3 over 3 edges, CNT=1, holds until QR=1.
